// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: host-side initiator for the 8-bit ALU tile.
// Takes one command (opcode, A, B), sends it to the tile as a three-beat
// frame, waits WAIT_CYCLES cycles, samples the tile result and returns it
// on a valid/ready response port. Every output comes straight from a flop.
`timescale 1ns/1ps

module alu_cmd_driver #(
  // Cycles between the last frame beat and the cycle whose end samples
  // bus_in. Legal range 1..15 (the wait counter is 4 bits wide).
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_opcode,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [7:0] bus_out,
  output logic       bus_valid,
  output logic       bus_sof,
  input  logic [7:0] bus_in,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [3:0] rsp_opcode,
  output logic       busy,
  output logic [7:0] frame_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_OPA,
    ST_OPB,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_opcode;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [3:0] r_wait_cnt;

  logic       r_cmd_ready;
  logic [7:0] r_bus_out;
  logic       r_bus_valid;
  logic       r_bus_sof;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_result;
  logic [3:0] r_rsp_opcode;
  logic       r_busy;
  logic [7:0] r_frame_count;

  // Frame sequencer. Bus outputs are computed one state ahead, so the
  // registered value seen in a cycle always belongs to the state of that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_opcode      <= 4'h0;
      r_a           <= 8'h00;
      r_b           <= 8'h00;
      r_wait_cnt    <= 4'h0;
      r_cmd_ready   <= 1'b0;
      r_bus_out     <= 8'h00;
      r_bus_valid   <= 1'b0;
      r_bus_sof     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= 8'h00;
      r_rsp_opcode  <= 4'h0;
      r_busy        <= 1'b0;
      r_frame_count <= 8'h00;
    end else begin
      // The bus is idle unless the next state is a beat state.
      r_bus_out   <= 8'h00;
      r_bus_valid <= 1'b0;
      r_bus_sof   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // cmd_ready is held low under reset, so it rises one edge after release.
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_opcode    <= cmd_opcode;
            r_a         <= cmd_a;
            r_b         <= cmd_b;
            r_bus_out   <= {cmd_opcode, 4'h0};
            r_bus_valid <= 1'b1;
            r_bus_sof   <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_OPC;
          end
        end
        ST_OPC: begin
          r_bus_out   <= r_a;
          r_bus_valid <= 1'b1;
          r_state     <= ST_OPA;
        end
        ST_OPA: begin
          r_bus_out   <= r_b;
          r_bus_valid <= 1'b1;
          r_state     <= ST_OPB;
        end
        ST_OPB: begin
          r_wait_cnt <= WAIT_LOAD;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_wait_cnt == 4'h0) begin
            // Single sampling edge for the tile result.
            r_rsp_result <= bus_in;
            r_rsp_opcode <= r_opcode;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_frame_count <= r_frame_count + 8'd1;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          r_cmd_ready <= 1'b0;
          r_busy      <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign bus_out     = r_bus_out;
  assign bus_valid   = r_bus_valid;
  assign bus_sof     = r_bus_sof;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_opcode  = r_rsp_opcode;
  assign busy        = r_busy;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: scoreboard bench for alu_cmd_driver.
// Three instances (WAIT_CYCLES 2, 1, 15) share clock and reset. Each has a
// small ALU tile model that drives (A+B) on bus_in only in the cycle the
// driver should sample it, and a monitor that pops expected beats and
// responses from per-instance queues filled by the stimulus tasks.
`timescale 1ns/1ps

module tb_alu_cmd_driver;

  typedef struct packed {
    logic        sof;
    logic [7:0]  data;
    logic [31:0] cyc;
  } beat_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [7:0]  res;
    logic [31:0] vcyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  logic [2:0] cmd_valid = 3'b000;
  logic [2:0] rsp_ready = 3'b111;
  logic [2:0] cmd_ready;
  logic [2:0] bus_valid;
  logic [2:0] bus_sof;
  logic [2:0] rsp_valid;
  logic [2:0] busy;
  logic [3:0] cmd_opcode [3];
  logic [7:0] cmd_a [3];
  logic [7:0] cmd_b [3];
  logic [7:0] bus_out [3];
  logic [7:0] rsp_result [3];
  logic [3:0] rsp_opcode [3];
  logic [7:0] frame_count [3];

  beat_t beat_q [3][$];
  rsp_t  rsp_q  [3][$];

  // 100 MHz clock
  always #5 clk = ~clk;

  // Cycle index: cycle N is the interval that starts at the N-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input int idx);
    return (idx == 0) ? 2 : ((idx == 1) ? 1 : 15);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, required %0h (cycle %0d)", name, idx, act, exp, cyc);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int W = (gi == 0) ? 2 : ((gi == 1) ? 1 : 15);
      logic [7:0] bus_in = 8'h00;
      logic [7:0] m_a = 8'h00;
      logic [7:0] m_res = 8'h00;
      int         m_idx = 0;
      int         m_tgt = -1;
      logic       prev_v = 1'b0;
      int         rise = 0;
      logic [7:0] m_fc = 8'h00;
      beat_t      b;
      rsp_t       r;

      alu_cmd_driver #(.WAIT_CYCLES(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid[gi]),
        .cmd_ready  (cmd_ready[gi]),
        .cmd_opcode (cmd_opcode[gi]),
        .cmd_a      (cmd_a[gi]),
        .cmd_b      (cmd_b[gi]),
        .bus_out    (bus_out[gi]),
        .bus_valid  (bus_valid[gi]),
        .bus_sof    (bus_sof[gi]),
        .bus_in     (bus_in),
        .rsp_valid  (rsp_valid[gi]),
        .rsp_ready  (rsp_ready[gi]),
        .rsp_result (rsp_result[gi]),
        .rsp_opcode (rsp_opcode[gi]),
        .busy       (busy[gi]),
        .frame_count(frame_count[gi])
      );

      // Tile model: result valid on bus_in only in cycle (B beat + W), inverted otherwise.
      always @(posedge clk) begin
        if (!rst) begin
          m_idx = 0;
          m_tgt = -1;
        end else if (bus_valid[gi]) begin
          if (bus_sof[gi]) begin
            m_idx = 1;
          end else if (m_idx == 1) begin
            m_a   = bus_out[gi];
            m_idx = 2;
          end else if (m_idx == 2) begin
            m_res = m_a + bus_out[gi];
            m_tgt = cyc + W;
            m_idx = 0;
          end
        end
        bus_in <= ((cyc + 1) == m_tgt) ? m_res : ~m_res;
      end

      // Monitor: compares beats, responses and frame_count against the queues.
      always @(negedge clk) begin
        if (!rst) begin
          m_fc   = 8'h00;
          prev_v = 1'b0;
        end else begin
          if (bus_valid[gi]) begin
            if (beat_q[gi].size() == 0) begin
              n_vec++;
              n_bad++;
              $display("FAIL beat_unexpected[%0d]: got beat %02h sof %0b in cycle %0d, required none",
                       gi, bus_out[gi], bus_sof[gi], cyc);
            end else begin
              b = beat_q[gi].pop_front();
              chk("beat_data", gi, 32'(bus_out[gi]), 32'(b.data));
              chk("beat_sof", gi, 32'(bus_sof[gi]), 32'(b.sof));
              chk("beat_cycle", gi, 32'(cyc), b.cyc);
            end
          end else begin
            chk("bus_idle", gi, 32'({bus_sof[gi], bus_out[gi]}), 32'h0);
          end
          if (rsp_valid[gi] && !prev_v) rise = cyc;
          if (rsp_valid[gi] && rsp_ready[gi]) begin
            if (rsp_q[gi].size() == 0) begin
              n_vec++;
              n_bad++;
              $display("FAIL rsp_unexpected[%0d]: got result %02h op %0h in cycle %0d, required none",
                       gi, rsp_result[gi], rsp_opcode[gi], cyc);
            end else begin
              r = rsp_q[gi].pop_front();
              chk("rsp_result", gi, 32'(rsp_result[gi]), 32'(r.res));
              chk("rsp_opcode", gi, 32'(rsp_opcode[gi]), 32'(r.op));
              chk("rsp_cycle", gi, 32'(rise), r.vcyc);
            end
          end
          prev_v = rsp_valid[gi];
        end
        chk("frame_count", gi, 32'(frame_count[gi]), 32'(m_fc));
        if (rst && rsp_valid[gi] && rsp_ready[gi]) m_fc = m_fc + 8'd1;
      end
    end
  endgenerate

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait for acceptance, queue expected beats/response.
  task automatic send(input int idx, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_r, input bit keep, input bit track, output int t);
    beat_t bt;
    rsp_t  rp;
    cmd_opcode[idx] = op;
    cmd_a[idx]      = a;
    cmd_b[idx]      = b;
    cmd_valid[idx]  = 1'b1;
    t = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cmd_ready[idx]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL cmd_accept[%0d]: got no handshake in 100 cycles, required acceptance", idx);
      cmd_valid[idx] = 1'b0;
      return;
    end
    bt.sof = 1'b1; bt.data = {op, 4'h0}; bt.cyc = 32'(t + 1); beat_q[idx].push_back(bt);
    bt.sof = 1'b0; bt.data = a;          bt.cyc = 32'(t + 2); beat_q[idx].push_back(bt);
    bt.sof = 1'b0; bt.data = b;          bt.cyc = 32'(t + 3); beat_q[idx].push_back(bt);
    if (track) begin
      rp.op = op; rp.res = exp_r; rp.vcyc = 32'(t + 4 + wc(idx));
      rsp_q[idx].push_back(rp);
    end
    step();
    if (!keep) cmd_valid[idx] = 1'b0;
  endtask

  // Wait until every queued response of an instance has been handshaken.
  task automatic drain(input int idx);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rsp_q[idx].size() == 0) break;
    end
    if (rsp_q[idx].size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain[%0d]: got %0d responses outstanding after 200 cycles, required 0",
               idx, rsp_q[idx].size());
    end
    @(negedge clk);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 50000 cycles, required completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus sequence.
  initial begin
    int t;
    int prev_t;
    logic [7:0] av;
    logic [3:0] opv;
    logic [3:0] ops  [4];
    logic [7:0] as   [4];
    logic [7:0] bs   [4];
    logic [7:0] exps [4];

    for (int i = 0; i < 3; i++) begin
      cmd_opcode[i] = 4'h0;
      cmd_a[i]      = 8'h00;
      cmd_b[i]      = 8'h00;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_cmd_ready", i, 32'(cmd_ready[i]), 32'h0);
      chk("rst_busy", i, 32'(busy[i]), 32'h0);
      chk("rst_bus_valid", i, 32'(bus_valid[i]), 32'h0);
      chk("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'h0);
      chk("rst_rsp_result", i, 32'(rsp_result[i]), 32'h0);
      chk("rst_rsp_opcode", i, 32'(rsp_opcode[i]), 32'h0);
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", 0, 32'(cmd_ready[0]), 32'h0);
    @(negedge clk);
    chk("ready_after_edge", 0, 32'(cmd_ready[0]), 32'h1);

    // Single op: 12+34 = 46
    step();
    send(0, 4'h0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b1, t);
    drain(0);
    chk("single_fc", 0, 32'(frame_count[0]), 32'h1);

    // Response backpressure: FF+01 = 00, held for 10 cycles
    step();
    rsp_ready[0] = 1'b0;
    send(0, 4'h1, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, t);
    for (int k = 0; k < 100; k++) begin
      if (rsp_valid[0]) break;
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) begin
      chk("bp_rsp_valid", 0, 32'(rsp_valid[0]), 32'h1);
      chk("bp_rsp_result", 0, 32'(rsp_result[0]), 32'h00);
      chk("bp_rsp_opcode", 0, 32'(rsp_opcode[0]), 32'h1);
      chk("bp_cmd_ready", 0, 32'(cmd_ready[0]), 32'h0);
      if (k < 9) begin
        step();
        cmd_opcode[0] = 4'hF;
        cmd_a[0]      = 8'hAA;
        cmd_b[0]      = 8'h55;
        cmd_valid[0]  = (k % 2 == 0);
        @(negedge clk);
      end
    end
    step();
    cmd_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    drain(0);
    chk("bp_fc", 0, 32'(frame_count[0]), 32'h2);

    // Back-to-back with cmd_valid and rsp_ready held high
    ops[0] = 4'h2; as[0] = 8'h10; bs[0] = 8'h20; exps[0] = 8'h30;
    ops[1] = 4'h3; as[1] = 8'h55; bs[1] = 8'h66; exps[1] = 8'hBB;
    ops[2] = 4'h4; as[2] = 8'h80; bs[2] = 8'h80; exps[2] = 8'h00;
    ops[3] = 4'h5; as[3] = 8'hC8; bs[3] = 8'h37; exps[3] = 8'hFF;
    step();
    prev_t = 0;
    for (int i = 0; i < 4; i++) begin
      send(0, ops[i], as[i], bs[i], exps[i], (i < 3), 1'b1, t);
      if (i > 0) chk("b2b_period", i, 32'(t - prev_t), 32'd7);
      prev_t = t;
    end
    drain(0);
    chk("b2b_fc", 0, 32'(frame_count[0]), 32'h6);

    // Parameter edges: WAIT_CYCLES=1 (rsp at T+5) and 15 (rsp at T+19)
    step();
    send(1, 4'h6, 8'h21, 8'h43, 8'h64, 1'b0, 1'b1, t);
    drain(1);
    step();
    send(2, 4'h7, 8'hF0, 8'h0E, 8'hFE, 1'b0, 1'b1, t);
    drain(2);
    chk("w15_fc", 2, 32'(frame_count[2]), 32'h1);

    // Reset during the OPA beat
    step();
    send(0, 4'h8, 8'h5A, 8'h0F, 8'h69, 1'b0, 1'b0, t);
    step();
    chk("opa_beat_valid", 0, 32'(bus_valid[0]), 32'h1);
    chk("opa_beat_data", 0, 32'(bus_out[0]), 32'h5A);
    rst = 1'b0;
    #1;
    chk("mid_rst_bus_valid", 0, 32'(bus_valid[0]), 32'h0);
    chk("mid_rst_bus_out", 0, 32'(bus_out[0]), 32'h00);
    chk("mid_rst_bus_sof", 0, 32'(bus_sof[0]), 32'h0);
    chk("mid_rst_busy", 0, 32'(busy[0]), 32'h0);
    chk("mid_rst_cmd_ready", 0, 32'(cmd_ready[0]), 32'h0);
    chk("mid_rst_fc", 0, 32'(frame_count[0]), 32'h00);
    beat_q[0].delete();
    repeat (3) @(negedge clk);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready_before_edge", 0, 32'(cmd_ready[0]), 32'h0);
    @(negedge clk);
    chk("rel_ready_after_edge", 0, 32'(cmd_ready[0]), 32'h1);
    repeat (20) @(negedge clk);
    chk("rel_no_rsp", 0, 32'(rsp_valid[0]), 32'h0);

    // Counter wrap over 256 transactions
    for (int i = 0; i < 256; i++) begin
      av  = 8'(i);
      opv = av[3:0];
      step();
      send(0, opv, av, 8'h10, av + 8'h10, 1'b0, 1'b1, t);
      drain(0);
      if (i == 254) chk("wrap_ff", 0, 32'(frame_count[0]), 32'hFF);
      if (i == 255) chk("wrap_00", 0, 32'(frame_count[0]), 32'h00);
    end

    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("beats_left", i, 32'(beat_q[i].size()), 32'h0);
      chk("rsps_left", i, 32'(rsp_q[i].size()), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Host-side initiator for the 8-bit ALU tile. It accepts one command (opcode, operand A, operand B) over a valid/ready interface and serializes it onto the tile's 8-bit input bus as a three-beat frame. It waits a fixed number of cycles, then samples the tile's 8-bit result bus and returns the result over a valid/ready response interface. It sits between a test or host controller and the ALU tile's io_in/io_out pins. It is the write side that drives the tile and the read side that collects its result.

## Interface

Parameters:
- WAIT_CYCLES, default 2: cycles between the last frame beat and the cycle whose end samples bus_in. Legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept a command; high only in IDLE.
- cmd_opcode  in  4  ALU opcode.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- bus_out  out  8  frame beats to the ALU tile io_in; 8'h00 when not driving.
- bus_valid  out  1  high during each of the three frame beats.
- bus_sof  out  1  high on the opcode beat only.
- bus_in  in  8  result from the ALU tile io_out.
- rsp_valid  out  1  result held on rsp_result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_result  out  8  sampled bus_in.
- rsp_opcode  out  4  opcode of the command that produced rsp_result.
- busy  out  1  high in every state except IDLE.
- frame_count  out  8  count of completed response handshakes; wraps 8'hFF to 8'h00.

## Operation

- FSM states: IDLE, OPC, OPA, OPB, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, register opcode/A/B and go to OPC.
- OPC: bus_out={opcode,4'h0}, bus_valid=1, bus_sof=1; go to OPA.
- OPA: bus_out=A, bus_valid=1; go to OPB.
- OPB: bus_out=B, bus_valid=1; load the wait counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter is 0, the rising edge ending that cycle loads rsp_result<=bus_in and rsp_opcode<=opcode, and the FSM goes to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_result and rsp_opcode stay stable until the handshake.
  - On rsp_valid&&rsp_ready, increment frame_count and go to IDLE.
- cmd_valid outside IDLE is ignored; there is no queuing and commands are never dropped silently, because cmd_ready=0.
- In all non-beat states: bus_out=8'h00, bus_valid=0, bus_sof=0.
- All outputs are registered and glitch-free. bus_in is sampled only on the single defined edge.
- Reset (rst=0), at any time including mid-frame or in RESP:
  - Immediately returns the FSM to IDLE and abandons the frame.
  - Output values under reset: cmd_ready=0, busy=0, bus_out=8'h00, bus_valid=0, bus_sof=0, rsp_valid=0, rsp_result=8'h00, rsp_opcode=4'h0, frame_count=8'h00.
  - cmd_ready rises in the first clocked cycle after rst deasserts.

## Timing

- Command handshake in cycle T:
  - OPC beat in T+1, OPA in T+2, OPB in T+3.
  - WAIT occupies T+4 .. T+3+WAIT_CYCLES.
  - bus_in is sampled at the end of T+3+WAIT_CYCLES.
  - rsp_valid is first high in T+4+WAIT_CYCLES.
- rsp_ready may already be high when rsp_valid rises: the handshake completes in that same cycle.
- Response handshake in cycle R:
  - State is IDLE with cmd_ready=1 in R+1.
  - If a command is accepted in R+1, the next OPC beat is in R+2.
- Minimum command-to-command period is 5+WAIT_CYCLES cycles, reached with cmd_valid and rsp_ready held high.
- The tile's result must be stable on bus_in in cycle T+3+WAIT_CYCLES; the tile's latency dictates WAIT_CYCLES.

## Test plan

- Single op:
  - Stimulus: WAIT_CYCLES=2; bench ALU model returns (A+B)[7:0] two cycles after the B beat; command op=4'h0, A=8'h12, B=8'h34.
  - Required: beats 8'h00 (sof=1), 8'h12, 8'h34; rsp_valid exactly 6 cycles after the command handshake; rsp_result=8'h46, rsp_opcode=4'h0; frame_count=1 after the handshake.
- Response backpressure:
  - Stimulus: A=8'hFF, B=8'h01; rsp_ready low for 10 cycles.
  - Required: rsp_valid=1 and rsp_result=8'h00 held stable for all 10 cycles; cmd_ready=0 throughout; cmd_valid pulses in that window are not accepted.
- Back-to-back:
  - Stimulus: cmd_valid and rsp_ready held high; 4 distinct commands.
  - Required: each frame starts 7 cycles after the previous one; results return in order with the matching rsp_opcode.
- Reset mid-frame:
  - Stimulus: assert rst during the OPA beat.
  - Required: bus_valid=0 and bus_out=8'h00 immediately (asynchronous); no rsp_valid ever appears for that frame; frame_count=0; cmd_ready=1 in the first clocked cycle after release.
- Counter wrap:
  - Stimulus: 256 completed transactions.
  - Required: frame_count reads 8'hFF, then 8'h00.
- Parameter edge:
  - Stimulus: WAIT_CYCLES=1 and WAIT_CYCLES=15.
  - Required: rsp_valid at T+5 and T+19 respectively; the sampled value equals bus_in in cycle T+4 and cycle T+18 respectively.
